dcache_mem_responder: RTL and testbench
=======================================

DCACHE_MEM_RESPONDER -- requirements
Module: dcache_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS_N, default 4096, backing-store depth in MEM_DATA_W (64-bit) words; power of two.
REQ-002 SHALL have parameter RD_LATENCY, default 4, cycles from read-request acceptance to first read beat valid; legal range 1..15.
REQ-003 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port mem_req_vld  in  1  line request valid.
REQ-006 SHALL have port mem_req_wr  in  1  1 = line write (evict), 0 = line fill read.
REQ-007 SHALL have port mem_req_addr  in  ADDR_W  byte address (addr_t); low CACHE_LINE_ADDR_W bits ignored.
REQ-008 SHALL have port mem_req_rdy  out  1  request accepted when vld&&rdy.
REQ-009 SHALL have port mem_wdat_vld  in  1  write beat valid.
REQ-010 SHALL have port mem_wdat  in  MEM_DATA_W  write beat data.
REQ-011 SHALL have port mem_wdat_rdy  out  1  write beat accepted when vld&&rdy.
REQ-012 SHALL have port mem_rdat_vld  out  1  read beat valid.
REQ-013 SHALL have port mem_rdat  out  MEM_DATA_W  read beat data.
REQ-014 SHALL have port mem_rdat_last  out  1  marks final beat of a line.
REQ-015 SHALL have port mem_rdat_rdy  in  1  read beat consumed when vld&&rdy.
REQ-016 SHALL have port mem_wr_ack  out  1  single-cycle pulse, line write committed.

Function
REQ-017 SHALL implement FSM states IDLE, RD_WAIT, RD_BEAT, WR_BEAT, WR_ACK.
REQ-018 SHALL assert mem_req_rdy only in IDLE; one outstanding request at a time.
REQ-019 SHALL on accepted read go IDLE->RD_WAIT, load latency counter with RD_LATENCY-1, latch line index.
REQ-020 SHALL in RD_WAIT decrement counter each cycle; at zero enter RD_BEAT with beat 0 data already registered (first mem_rdat_vld exactly RD_LATENCY cycles after acceptance).
REQ-021 SHALL return RAM_DAT_LINE_N (4) beats in ascending order 0..3; word address = {line index, beat}, modulo MEM_WORDS_N.
REQ-022 SHALL hold mem_rdat_vld, mem_rdat, mem_rdat_last stable while mem_rdat_rdy low; advance one beat per handshake.
REQ-023 SHALL assert mem_rdat_last with beat 3 only; handshake on it returns to IDLE next cycle.
REQ-024 SHALL on accepted write go IDLE->WR_BEAT, assert mem_wdat_rdy only in WR_BEAT, store each accepted beat same cycle to ascending word 0..3.
REQ-025 SHALL after 4th write beat enter WR_ACK, pulse mem_wr_ack for exactly one cycle, then IDLE.
REQ-026 SHALL make written data visible to any read request accepted after mem_wr_ack.
REQ-027 SHALL ignore mem_wdat_vld outside WR_BEAT and mem_rdat_rdy outside RD_BEAT.
REQ-028 SHALL wrap beat counter (RAM_DAT_LINE_W bits) and latency counter without overflow side effects.

Reset
REQ-029 SHALL on rst force FSM to IDLE, counters to 0, and mem_req_rdy=0, mem_wdat_rdy=0, mem_rdat_vld=0, mem_rdat=0, mem_rdat_last=0, mem_wr_ack=0 the following cycle; mem_req_rdy rises the cycle after rst deasserts.
REQ-030 SHALL abort any in-flight transfer on rst mid-operation; partially written lines keep beats already stored; store contents are never reset.

Configuration
REQ-031 SHALL, when DCACHE_MEM_RESPONDER_ERR_EN is defined, add output mem_rsp_err (1 bit) asserted with mem_rdat_last or mem_wr_ack when the line address exceeds MEM_WORDS_N range (no wrap; reads return 0, writes discarded).
REQ-032 SHALL, when DCACHE_MEM_RESPONDER_ERR_EN is undefined, omit mem_rsp_err and wrap addresses modulo MEM_WORDS_N per REQ-021.

Structure
REQ-033 SHALL place FSM state enum (mem_rsp_state_t), mem_beat_t (RAM_DAT_LINE_W bits) and MEM_BEATS_N = RAM_DAT_LINE_N in dcache_blocking_pkg.
REQ-034 SHALL instantiate one sub-module dcache_mem_store: 1R1W synchronous RAM, MEM_DATA_W x MEM_WORDS_N, 1-cycle read latency.

Verification
REQ-035 SHALL cover: write addr 0x40 beats 0x11..,0x22..,0x33..,0x44.. -> mem_wr_ack one cycle after beat 4; then read 0x40 -> same 4 beats, last on 4th, first valid 4 cycles after acceptance.
REQ-036 SHALL cover: read 0x40 with mem_rdat_rdy low for 3 cycles on beat 1 -> beat 1 data/vld held stable, no beat lost or duplicated.
REQ-037 SHALL cover: read addr 0x5C -> treated as line 0x40, beats from word 8 onward.
REQ-038 SHALL cover: rst asserted during RD_BEAT beat 2 -> next cycle all outputs 0, mem_req_rdy=1 after release, new request served normally.
REQ-039 SHALL cover: mem_req_vld held high during busy transfer and mem_wdat_vld during read -> no second acceptance, no store write.
REQ-040 SHALL cover: with DCACHE_MEM_RESPONDER_ERR_EN, read line beyond MEM_WORDS_N*8 bytes -> 4 zero beats, mem_rsp_err with last; without macro -> wrapped data returned.

Source files
------------

// File: rtl/dcache_blocking_pkg.sv
// Shared types and constants for the blocking data-cache memory side.
// A cache line is MEM_BEATS_N beats of MEM_DATA_W bits (32 bytes).
package dcache_blocking_pkg;

  localparam int ADDR_W            = 32;
  localparam int MEM_DATA_W        = 64;
  localparam int RAM_DAT_LINE_N    = 4;
  localparam int RAM_DAT_LINE_W    = 2;
  localparam int MEM_BEATS_N       = RAM_DAT_LINE_N;
  localparam int CACHE_LINE_ADDR_W = 5;
  localparam int LINE_IDX_W        = ADDR_W - CACHE_LINE_ADDR_W;
  localparam int LAT_W             = 4;

  typedef logic [ADDR_W-1:0]         addr_t;
  typedef logic [RAM_DAT_LINE_W-1:0] mem_beat_t;
  typedef logic [LINE_IDX_W-1:0]     line_idx_t;

  localparam mem_beat_t LAST_BEAT = mem_beat_t'(MEM_BEATS_N - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_BEAT = 3'd2,
    WR_BEAT = 3'd3,
    WR_ACK  = 3'd4
  } mem_rsp_state_t;

  // Line index of a byte address; the offset inside the line is dropped.
  function automatic line_idx_t line_of(addr_t addr);
    return addr[ADDR_W-1:CACHE_LINE_ADDR_W];
  endfunction

endpackage

// File: rtl/dcache_mem_store.sv
// Backing store: 1R1W synchronous RAM with a registered read port
// (data appears the cycle after rd_en_i). Contents are never reset.
module dcache_mem_store
  import dcache_blocking_pkg::*;
#(
  parameter int WORDS_N = 4096,
  parameter int AW      = $clog2(WORDS_N)
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [MEM_DATA_W-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [MEM_DATA_W-1:0] wr_data_i
);

  logic [MEM_DATA_W-1:0] mem_q [WORDS_N];
  logic [MEM_DATA_W-1:0] rd_data_q;

  // Write port: store the word on the clock edge it is presented.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read port: the output register holds its value until the next read.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the blocking data cache: serves one line
// fill (4 read beats after RD_LATENCY cycles) or one line evict (4 write
// beats then a one-cycle ack) at a time from an internal RAM.
// Optional build macro DCACHE_MEM_RESPONDER_ERR_EN: out-of-range lines
// are flagged on mem_rsp_err (reads return 0, writes are dropped)
// instead of wrapping modulo MEM_WORDS_N.
module dcache_mem_responder
  import dcache_blocking_pkg::*;
#(
  parameter int MEM_WORDS_N = 4096,
  parameter int RD_LATENCY  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_vld,
  input  logic                  mem_req_wr,
  input  addr_t                 mem_req_addr,
  output logic                  mem_req_rdy,
  input  logic                  mem_wdat_vld,
  input  logic [MEM_DATA_W-1:0] mem_wdat,
  output logic                  mem_wdat_rdy,
  output logic                  mem_rdat_vld,
  output logic [MEM_DATA_W-1:0] mem_rdat,
  output logic                  mem_rdat_last,
  input  logic                  mem_rdat_rdy,
  output logic                  mem_wr_ack
`ifdef DCACHE_MEM_RESPONDER_ERR_EN
  ,
  output logic                  mem_rsp_err
`endif
);

  localparam int MEM_AW = $clog2(MEM_WORDS_N);

  mem_rsp_state_t        state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  mem_beat_t             beat_q, beat_d;
  line_idx_t             line_q, line_d;
  logic                  line_bad;

  logic                  ram_re;
  logic [MEM_AW-1:0]     ram_raddr;
  logic                  ram_we;
  logic [MEM_AW-1:0]     ram_waddr;
  logic [MEM_DATA_W-1:0] ram_rdata;

  // Word address {line, beat}; truncation to MEM_AW gives the modulo wrap.
  function automatic logic [MEM_AW-1:0] word_addr(line_idx_t line, mem_beat_t beat);
    return MEM_AW'({line, beat});
  endfunction

  // State register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
    end
  end

  // Line index of the transfer in flight (pure data, no reset needed).
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

`ifdef DCACHE_MEM_RESPONDER_ERR_EN
  logic err_q, err_d;

  assign err_d = (state_q == IDLE) ?
                 (line_of(mem_req_addr) >= LINE_IDX_W'(MEM_WORDS_N / MEM_BEATS_N)) : err_q;

  // Out-of-range flag captured when the request is accepted.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign line_bad    = err_q;
  assign mem_rsp_err = line_bad && (mem_rdat_last || mem_wr_ack);
`else
  assign line_bad = 1'b0;
`endif

  // Next-state, counter and RAM-control logic.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    line_d  = line_q;
    ram_re  = 1'b0;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_vld && !rst) begin
          line_d = line_of(mem_req_addr);
          beat_d = '0;
          if (mem_req_wr) begin
            state_d = WR_BEAT;
          end else begin
            state_d = RD_WAIT;
            lat_d   = LAT_W'(RD_LATENCY - 1);
          end
        end
      end
      RD_WAIT: begin
        // Launch the beat-0 read one cycle early so it is registered on entry.
        if (lat_q == '0) begin
          state_d = RD_BEAT;
          ram_re  = 1'b1;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RD_BEAT: begin
        if (mem_rdat_rdy) begin
          beat_d = beat_q + mem_beat_t'(1);
          if (beat_q == LAST_BEAT) state_d = IDLE;
          else                     ram_re  = 1'b1;
        end
      end
      WR_BEAT: begin
        if (mem_wdat_vld && !rst) begin
          ram_we = !line_bad;
          beat_d = beat_q + mem_beat_t'(1);
          if (beat_q == LAST_BEAT) state_d = WR_ACK;
        end
      end
      WR_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_raddr = word_addr(line_q, beat_d);
  assign ram_waddr = word_addr(line_q, beat_q);

  // Port outputs decoded from the current state.
  always_comb begin
    mem_req_rdy   = 1'b0;
    mem_wdat_rdy  = 1'b0;
    mem_rdat_vld  = 1'b0;
    mem_rdat      = '0;
    mem_rdat_last = 1'b0;
    mem_wr_ack    = 1'b0;
    unique case (state_q)
      IDLE:    mem_req_rdy  = !rst;
      WR_BEAT: mem_wdat_rdy = !rst;
      WR_ACK:  mem_wr_ack   = 1'b1;
      RD_BEAT: begin
        mem_rdat_vld  = 1'b1;
        mem_rdat      = line_bad ? '0 : ram_rdata;
        mem_rdat_last = (beat_q == LAST_BEAT);
      end
      default: ;
    endcase
  end

  dcache_mem_store #(
    .WORDS_N (MEM_WORDS_N),
    .AW      (MEM_AW)
  ) u_store (
    .clk_i     (clk),
    .rd_en_i   (ram_re),
    .rd_addr_i (ram_raddr),
    .rd_data_o (ram_rdata),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_data_i (mem_wdat)
  );

  // Line-offset bits and, without the range check, the high line bits
  // are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{mem_req_addr[CACHE_LINE_ADDR_W-1:0], line_q};

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: directed line reads/writes, stalls,
// mid-transfer reset and address wrap / range error, checked each cycle
// against a transaction-level memory model plus literal expectations.
module tb_dcache_mem_responder;

  localparam int N = 4096;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_vld, mem_req_wr, mem_req_rdy;
  logic [31:0] mem_req_addr;
  logic        mem_wdat_vld, mem_wdat_rdy;
  logic [63:0] mem_wdat, mem_rdat;
  logic        mem_rdat_vld, mem_rdat_last, mem_rdat_rdy, mem_wr_ack;
`ifdef DCACHE_MEM_RESPONDER_ERR_EN
  logic        mem_rsp_err;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_mem_responder #(.MEM_WORDS_N(N), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .mem_req_vld(mem_req_vld), .mem_req_wr(mem_req_wr),
    .mem_req_addr(mem_req_addr), .mem_req_rdy(mem_req_rdy),
    .mem_wdat_vld(mem_wdat_vld), .mem_wdat(mem_wdat), .mem_wdat_rdy(mem_wdat_rdy),
    .mem_rdat_vld(mem_rdat_vld), .mem_rdat(mem_rdat),
    .mem_rdat_last(mem_rdat_last), .mem_rdat_rdy(mem_rdat_rdy),
    .mem_wr_ack(mem_wr_ack)
`ifdef DCACHE_MEM_RESPONDER_ERR_EN
    , .mem_rsp_err(mem_rsp_err)
`endif
  );

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RD = 1, M_WR = 2, M_ACK = 3;
  int          m_mode = M_IDLE;
  int          m_age, m_beats, m_line;
  bit          m_started = 0;
  logic [63:0] mmem [N];

  function automatic bit line_bad(input int line);
`ifdef DCACHE_MEM_RESPONDER_ERR_EN
    return line >= N / 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_of(input int line, input int beat);
    return (line * 4 + beat) % N;
  endfunction

  always @(posedge clk) begin
    m_started <= 1'b1;
    if (rst) begin
      m_mode <= M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (mem_req_vld) begin
          m_line  <= int'(mem_req_addr >> 5);
          m_beats <= 0;
          m_age   <= 0;
          m_mode  <= mem_req_wr ? M_WR : M_RD;
        end
        M_RD: begin
          m_age <= m_age + 1;
          if (m_age >= L && mem_rdat_rdy) begin
            m_beats <= m_beats + 1;
            if (m_beats == 3) m_mode <= M_IDLE;
          end
        end
        M_WR: if (mem_wdat_vld) begin
          if (!line_bad(m_line)) mmem[word_of(m_line, m_beats)] <= mem_wdat;
          m_beats <= m_beats + 1;
          if (m_beats == 3) m_mode <= M_ACK;
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_started) begin
      logic        e_vld;
      logic [63:0] e_dat;
      e_vld = (m_mode == M_RD) && (m_age >= L);
      e_dat = (e_vld && !line_bad(m_line)) ? mmem[word_of(m_line, m_beats)] : 64'h0;
      chk1("req_rdy", mem_req_rdy, (m_mode == M_IDLE) && !rst);
      chk1("wdat_rdy", mem_wdat_rdy, (m_mode == M_WR) && !rst);
      chk1("rdat_vld", mem_rdat_vld, e_vld);
      chk64("rdat", mem_rdat, e_dat);
      chk1("rdat_last", mem_rdat_last, e_vld && (m_beats == 3));
      chk1("wr_ack", mem_wr_ack, m_mode == M_ACK);
`ifdef DCACHE_MEM_RESPONDER_ERR_EN
      chk1("rsp_err", mem_rsp_err, line_bad(m_line) &&
           ((e_vld && m_beats == 3) || m_mode == M_ACK));
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] wbuf [4];
  logic [63:0] rbuf [4];
  logic        rlast [4];
  int          rlat;
  logic [63:0] hold_q [$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a);
    int t;
    bit hs;
    mem_req_vld = 1; mem_req_wr = 1; mem_req_addr = a;
    hs = 0; t = 0;
    while (!hs && t < 20) begin @(negedge clk); hs = mem_req_rdy; step(); t++; end
    chk1("wr_req_accept", hs, 1'b1);
    mem_req_vld = 0;
    for (int b = 0; b < 4; b++) begin
      mem_wdat_vld = 1; mem_wdat = wbuf[b];
      hs = 0; t = 0;
      while (!hs && t < 20) begin @(negedge clk); hs = mem_wdat_rdy; step(); t++; end
      chk1("wr_beat_accept", hs, 1'b1);
    end
    mem_wdat_vld = 0;
    @(negedge clk); chk1("wr_ack_pulse", mem_wr_ack, 1'b1); step();
    @(negedge clk); chk1("wr_ack_single", mem_wr_ack, 1'b0); step();
  endtask

  task automatic do_read(input logic [31:0] a, input int stall_beat, input int stall_n,
                         input int rst_beat, input bit keep_busy);
    int t, got, stall_left, cnt;
    bit hs, seen;
    mem_req_vld = 1; mem_req_wr = 0; mem_req_addr = a; mem_rdat_rdy = 1;
    if (keep_busy) begin mem_wdat_vld = 1; mem_wdat = 64'hDEADBEEF_DEADBEEF; end
    hs = 0; t = 0;
    while (!hs && t < 20) begin @(negedge clk); hs = mem_req_rdy; step(); t++; end
    chk1("rd_req_accept", hs, 1'b1);
    if (!keep_busy) mem_req_vld = 0;
    got = 0; stall_left = stall_n; cnt = 0; seen = 0; t = 0; rlat = -1;
    hold_q.delete();
    for (int i = 0; i < 4; i++) begin rbuf[i] = 'x; rlast[i] = 1'bx; end
    while (got < 4 && t < 100) begin
      if (rst_beat == got && mem_rdat_vld) begin
        rst = 1; mem_rdat_rdy = 0;
        step();
        @(negedge clk);
        chk1("rst_req_rdy", mem_req_rdy, 1'b0);
        chk1("rst_rdat_vld", mem_rdat_vld, 1'b0);
        chk64("rst_rdat", mem_rdat, 64'h0);
        chk1("rst_rdat_last", mem_rdat_last, 1'b0);
        chk1("rst_wdat_rdy", mem_wdat_rdy, 1'b0);
        chk1("rst_wr_ack", mem_wr_ack, 1'b0);
        step(); rst = 0;
        @(negedge clk); chk1("post_rst_req_rdy", mem_req_rdy, 1'b1);
        step();
        mem_req_vld = 0; mem_wdat_vld = 0; mem_rdat_rdy = 1;
        return;
      end
      mem_rdat_rdy = !(mem_rdat_vld && got == stall_beat && stall_left > 0);
      if (!mem_rdat_rdy) stall_left--;
      @(negedge clk);
      if (mem_rdat_vld) begin
        if (!seen) begin seen = 1; rlat = cnt; end
        if (mem_rdat_rdy) begin rbuf[got] = mem_rdat; rlast[got] = mem_rdat_last; got++; end
        else hold_q.push_back(mem_rdat);
      end
      step(); cnt++; t++;
    end
    chk1("rd_complete", got == 4, 1'b1);
    mem_req_vld = 0; mem_wdat_vld = 0; mem_rdat_rdy = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; mem_req_vld = 0; mem_req_wr = 0; mem_req_addr = '0;
    mem_wdat_vld = 0; mem_wdat = '0; mem_rdat_rdy = 0;
    step(); step();
    @(negedge clk);
    chk1("reset_req_rdy", mem_req_rdy, 1'b0);
    chk1("reset_rdat_vld", mem_rdat_vld, 1'b0);
    chk64("reset_rdat", mem_rdat, 64'h0);
    chk1("reset_wr_ack", mem_wr_ack, 1'b0);
    step(); rst = 0;
    @(negedge clk); chk1("reset_release_rdy", mem_req_rdy, 1'b1);
    step();

    // Line write then read-back at 0x40.
    wbuf[0] = 64'h1111111111111111; wbuf[1] = 64'h2222222222222222;
    wbuf[2] = 64'h3333333333333333; wbuf[3] = 64'h4444444444444444;
    do_write(32'h40);
    do_read(32'h40, -1, 0, -1, 0);
    chk64("rd40_latency", 64'(rlat), 64'd4);
    chk64("rd40_b0", rbuf[0], 64'h1111111111111111);
    chk64("rd40_b1", rbuf[1], 64'h2222222222222222);
    chk64("rd40_b2", rbuf[2], 64'h3333333333333333);
    chk64("rd40_b3", rbuf[3], 64'h4444444444444444);
    chk1("rd40_last2", rlast[2], 1'b0);
    chk1("rd40_last3", rlast[3], 1'b1);

    // Stall three cycles on beat 1.
    do_read(32'h40, 1, 3, -1, 0);
    chk64("stall_hold_count", 64'(hold_q.size()), 64'd3);
    foreach (hold_q[i]) chk64("stall_hold_data", hold_q[i], 64'h2222222222222222);
    chk64("stall_b1", rbuf[1], 64'h2222222222222222);
    chk64("stall_b2", rbuf[2], 64'h3333333333333333);

    // Unaligned address maps to its line.
    do_read(32'h5C, -1, 0, -1, 0);
    chk64("rd5c_b0", rbuf[0], 64'h1111111111111111);
    chk64("rd5c_b3", rbuf[3], 64'h4444444444444444);

    // Second line, then a read with request/write-valid held high.
    for (int b = 0; b < 4; b++) wbuf[b] = 64'hA0A0A0A0_00000000 | 64'(b);
    do_write(32'h60);
    do_read(32'h40, -1, 0, -1, 1);
    chk64("busy_b0", rbuf[0], 64'h1111111111111111);
    do_read(32'h40, -1, 0, -1, 0);
    chk64("busy_nowrite_b3", rbuf[3], 64'h4444444444444444);

    // Reset during beat 2, then a fresh request.
    do_read(32'h40, -1, 0, 2, 0);
    do_read(32'h60, -1, 0, -1, 0);
    chk64("post_rst_latency", 64'(rlat), 64'd4);
    chk64("post_rst_b0", rbuf[0], 64'hA0A0A0A0_00000000);
    chk64("post_rst_b3", rbuf[3], 64'hA0A0A0A0_00000003);

    // Beyond-range line: wraps to line 0, or is flagged with zero data.
    for (int b = 0; b < 4; b++) wbuf[b] = 64'hB0B0B0B0_00000000 | 64'(b);
    do_write(32'h0);
    do_read(32'h8000, -1, 0, -1, 0);
`ifdef DCACHE_MEM_RESPONDER_ERR_EN
    chk64("oor_rd_b0", rbuf[0], 64'h0);
    chk64("oor_rd_b3", rbuf[3], 64'h0);
`else
    chk64("wrap_rd_b0", rbuf[0], 64'hB0B0B0B0_00000000);
    chk64("wrap_rd_b3", rbuf[3], 64'hB0B0B0B0_00000003);
`endif
    for (int b = 0; b < 4; b++) wbuf[b] = 64'hC0C0C0C0_00000000 | 64'(b);
    do_write(32'h8000);
    do_read(32'h0, -1, 0, -1, 0);
`ifdef DCACHE_MEM_RESPONDER_ERR_EN
    chk64("oor_wr_dropped", rbuf[1], 64'hB0B0B0B0_00000001);
`else
    chk64("wrap_wr_b1", rbuf[1], 64'hC0C0C0C0_00000001);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
